// File: rtl/vme_system_arbiter.sv
// vme_system_arbiter: slot-1 VME system controller.
// Arbitrates BR3..BR0 onto the BG daisy-chain heads, raises BCLR on
// higher-priority contention and runs the global bus timer (BERR on
// unacknowledged data strobes).
module vme_system_arbiter #(
  parameter int unsigned ARB_MODE      = 0,
  parameter int unsigned GRANT_TIMEOUT = 64,
  parameter int unsigned BUS_TIMEOUT   = 1024
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       syscon_en,
  input  logic [3:0] vme_bus_request,
  input  logic       vme_bus_busy,
  input  logic       vme_as,
  input  logic [1:0] vme_ds,
  input  logic       vme_dtack,
  input  logic       vme_berr,
  output logic [3:0] vme_bus_grant,
  output logic       vme_bus_clear,
  output logic       vme_berr_out,
  output logic       timeout_flag,
  output logic [1:0] grant_level,
  output logic       status_led
);

  localparam int unsigned GCNT_W = $clog2(GRANT_TIMEOUT + 1);
  localparam int unsigned BCNT_W = $clog2(BUS_TIMEOUT + 1);
  localparam int unsigned SYNC_W = 9;

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_t;

  logic [SYNC_W-1:0] sync1_q, sync2_q;
  logic [3:0]        br_s;
  logic              bbsy_s, dtack_s, berr_s;
  logic [1:0]        ds_s;

  state_t            state_q, state_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              holdoff_q, holdoff_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [1:0]        level_d;
  logic              arb_win;
  logic [1:0]        sel_level;
  logic              sel_found;
  logic              higher_req;
  logic [3:0]        grant_d;
  logic              clear_d, led_d;

  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              bt_active, expire, berr_out_d, flag_d;

  // AS is deliberately ignored: the timer keys only on the data strobes.
  logic unused_as;
  assign unused_as = vme_as;

  // Two-flop synchronizers for every asynchronous VME input (idle = high).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {vme_bus_request, vme_bus_busy, vme_ds, vme_dtack, vme_berr};
      sync2_q <= sync1_q;
    end
  end

  assign br_s    = ~sync2_q[8:5];
  assign bbsy_s  = ~sync2_q[4];
  assign ds_s    = ~sync2_q[3:2];
  assign dtack_s = ~sync2_q[1];
  assign berr_s  = ~sync2_q[0];

  // Winner selection: fixed (highest index) or round robin below last grant.
  always_comb begin
    logic [1:0] idx;
    idx       = 2'd0;
    sel_level = 2'd0;
    sel_found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ARB_MODE == 0) idx = 2'(3 - i);
      else               idx = rr_ptr_q - 2'(i + 1);
      if (!sel_found && br_s[idx]) begin
        sel_found = 1'b1;
        sel_level = idx;
      end
    end
  end

  // Any request above the current owner's level (drives BCLR).
  always_comb begin
    higher_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (br_s[i] && (2'(i) > grant_level)) higher_req = 1'b1;
    end
  end

  // Arbiter state register plus registered arbiter outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      gcnt_q        <= '0;
      holdoff_q     <= 1'b0;
      rr_ptr_q      <= 2'd0;
      grant_level   <= 2'd0;
      vme_bus_grant <= 4'b1111;
      vme_bus_clear <= 1'b1;
      status_led    <= 1'b1;
    end else begin
      state_q       <= state_d;
      gcnt_q        <= gcnt_d;
      holdoff_q     <= holdoff_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_level   <= level_d;
      vme_bus_grant <= grant_d;
      vme_bus_clear <= clear_d;
      status_led    <= led_d;
    end
  end

  // Next-state logic; a released bus idles one cycle before re-arbitration.
  always_comb begin
    state_d   = state_q;
    gcnt_d    = '0;
    holdoff_d = 1'b0;
    arb_win   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!holdoff_q && !bbsy_s && sel_found) begin
          state_d = GRANT;
          arb_win = 1'b1;
        end
      end
      GRANT: begin
        gcnt_d = gcnt_q + GCNT_W'(1);
        if (bbsy_s)                                      state_d = BUSY;
        else if (gcnt_q == GCNT_W'(GRANT_TIMEOUT - 1))   state_d = IDLE;
      end
      BUSY: begin
        if (!bbsy_s) begin
          state_d   = IDLE;
          holdoff_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!syscon_en) begin
      state_d   = IDLE;
      gcnt_d    = '0;
      holdoff_d = 1'b0;
      arb_win   = 1'b0;
    end
  end

  // Next values of the arbiter outputs, derived from the next state.
  always_comb begin
    level_d  = arb_win ? sel_level : grant_level;
    rr_ptr_d = arb_win ? sel_level : rr_ptr_q;
    grant_d  = 4'b1111;
    if (state_d == GRANT) grant_d = ~(4'b0001 << level_d);
    clear_d  = !((ARB_MODE == 0) && (state_d == BUSY) && higher_req);
    led_d    = !(state_d == BUSY);
    if (!syscon_en) level_d = 2'd0;
  end

  // Bus timer: count unacknowledged strobe cycles, fire BERR once, saturate.
  always_comb begin
    bt_active  = (|ds_s) && !dtack_s && !berr_s;
    expire     = bt_active && (bcnt_q == BCNT_W'(BUS_TIMEOUT)) && vme_berr_out;
    bcnt_d     = bcnt_q;
    berr_out_d = vme_berr_out;
    if (bt_active && (bcnt_q != BCNT_W'(BUS_TIMEOUT))) bcnt_d = bcnt_q + BCNT_W'(1);
    if (expire) berr_out_d = 1'b0;
    if (!(|ds_s)) begin
      bcnt_d     = '0;
      berr_out_d = 1'b1;
    end
    flag_d = expire;
    if (!syscon_en) begin
      bcnt_d     = '0;
      berr_out_d = 1'b1;
      flag_d     = 1'b0;
    end
  end

  // Bus timer registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcnt_q       <= '0;
      vme_berr_out <= 1'b1;
      timeout_flag <= 1'b0;
    end else begin
      bcnt_q       <= bcnt_d;
      vme_berr_out <= berr_out_d;
      timeout_flag <= flag_d;
    end
  end

endmodule

// File: tb/tb_vme_system_arbiter.sv
// Directed bench for vme_system_arbiter: fixed-priority DUT (dut0) and
// round-robin DUT (dut1) share one set of bus inputs.
module tb_vme_system_arbiter;

  logic       clock = 1'b0;
  logic       rst_n = 1'b1;
  logic       syscon_en = 1'b1;
  logic [3:0] br_n = 4'hF;
  logic       bbsy_n = 1'b1;
  logic       as_n = 1'b1;
  logic [1:0] ds_n = 2'b11;
  logic       dtack_n = 1'b1;
  logic       berr_n = 1'b1;

  logic [3:0] bg0, bg1;
  logic       bclr0, bclr1, berro0, berro1, tof0, tof1, led0, led1;
  logic [1:0] lvl0, lvl1;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clock = ~clock;

  vme_system_arbiter #(.ARB_MODE(0), .GRANT_TIMEOUT(64), .BUS_TIMEOUT(1024)) dut0 (
    .clock(clock), .reset(rst_n), .syscon_en(syscon_en),
    .vme_bus_request(br_n), .vme_bus_busy(bbsy_n), .vme_as(as_n),
    .vme_ds(ds_n), .vme_dtack(dtack_n), .vme_berr(berr_n),
    .vme_bus_grant(bg0), .vme_bus_clear(bclr0), .vme_berr_out(berro0),
    .timeout_flag(tof0), .grant_level(lvl0), .status_led(led0));

  vme_system_arbiter #(.ARB_MODE(1), .GRANT_TIMEOUT(64), .BUS_TIMEOUT(1024)) dut1 (
    .clock(clock), .reset(rst_n), .syscon_en(syscon_en),
    .vme_bus_request(br_n), .vme_bus_busy(bbsy_n), .vme_as(as_n),
    .vme_ds(ds_n), .vme_dtack(dtack_n), .vme_berr(berr_n),
    .vme_bus_grant(bg1), .vme_bus_clear(bclr1), .vme_berr_out(berro1),
    .timeout_flag(tof1), .grant_level(lvl1), .status_led(led1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] get_sig(input int which);
    case (which)
      0:       return bg0;
      1:       return bg1;
      2:       return {3'b000, led0};
      default: return {3'b000, led1};
    endcase
  endfunction

  // Bounded wait; an expired bound shows up as a failed comparison.
  task automatic wait_sig(input int which, input logic [3:0] want, input string tag);
    int n = 0;
    while (get_sig(which) !== want && n < 40) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(get_sig(which)), 32'(want));
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    logic [31:0] e;
    logic [3:0]  ebg;
    int          offs[3] = '{1020, 1024, 1025};
    int          pulses;
    logic        berr_seen;

    // Reset state of both DUTs
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_bg0", 32'(bg0), 32'hF);      chk("rst_bg1", 32'(bg1), 32'hF);
    chk("rst_bclr0", 32'(bclr0), 32'h1);  chk("rst_bclr1", 32'(bclr1), 32'h1);
    chk("rst_berr0", 32'(berro0), 32'h1); chk("rst_berr1", 32'(berro1), 32'h1);
    chk("rst_tof0", 32'(tof0), 32'h0);    chk("rst_tof1", 32'(tof1), 32'h0);
    chk("rst_lvl0", 32'(lvl0), 32'h0);    chk("rst_lvl1", 32'(lvl1), 32'h0);
    chk("rst_led0", 32'(led0), 32'h1);    chk("rst_led1", 32'(led1), 32'h1);
    rst_n = 1'b1;
    tick(3);

    // Fixed priority: BR3 and BR1 together -> BG3 after 3 clocks
    br_n = 4'b0101;
    exp_q.push_back(32'd3);
    tick(2);
    chk("fix_bg_early", 32'(bg0), 32'hF);
    tick(1);
    chk("fix_bg3", 32'(bg0), 32'h7);
    e = exp_q.pop_front();
    chk("fix_lvl", 32'(lvl0), e);
    bbsy_n = 1'b0;
    tick(2);
    chk("fix_bg_hold", 32'(bg0), 32'h7);
    tick(1);
    chk("fix_bg_drop", 32'(bg0), 32'hF);
    chk("fix_led_busy", 32'(led0), 32'h0);
    br_n = 4'hF;
    bbsy_n = 1'b1;
    tick(2);
    chk("fix_led_still", 32'(led0), 32'h0);
    tick(1);
    chk("fix_led_idle", 32'(led0), 32'h1);
    tick(5);

    // Round robin with all four requests held: order 3,2,1,0,3
    pulse_reset();
    br_n = 4'b0000;
    exp_q.push_back(32'd3); exp_q.push_back(32'd2); exp_q.push_back(32'd1);
    exp_q.push_back(32'd0); exp_q.push_back(32'd3);
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      ebg = ~(4'b0001 << e[1:0]);
      wait_sig(1, ebg, "rr_grant");
      chk("rr_lvl", 32'(lvl1), e);
      bbsy_n = 1'b0;
      wait_sig(3, 4'd0, "rr_busy");
      chk("rr_no_bclr", 32'(bclr1), 32'h1);
      bbsy_n = 1'b1;
      wait_sig(3, 4'd1, "rr_release");
    end
    br_n = 4'hF;
    tick(5);

    // Fixed priority: level 1 owns bus, BR2 arrives -> BCLR
    pulse_reset();
    br_n = 4'b1101;
    wait_sig(0, 4'b1101, "bclr_grant1");
    bbsy_n = 1'b0;
    br_n = 4'hF;
    wait_sig(2, 4'd0, "bclr_busy");
    chk("bclr_idle_high", 32'(bclr0), 32'h1);
    br_n = 4'b1011;
    tick(3);
    chk("bclr_assert", 32'(bclr0), 32'h0);
    bbsy_n = 1'b1;
    exp_q.push_back(32'd2);
    tick(3);
    chk("bclr_release", 32'(bclr0), 32'h1);
    chk("rearb_gap3", 32'(bg0), 32'hF);
    tick(1);
    chk("rearb_gap4", 32'(bg0), 32'hF);
    tick(1);
    chk("rearb_bg2", 32'(bg0), 32'hB);
    e = exp_q.pop_front();
    chk("rearb_lvl", 32'(lvl0), e);

    // No BBSY response: grant held exactly 64 clocks, then re-granted
    tick(63);
    chk("gto_last", 32'(bg0), 32'hB);
    tick(1);
    chk("gto_drop", 32'(bg0), 32'hF);
    tick(1);
    chk("gto_regrant", 32'(bg0), 32'hB);
    br_n = 4'hF;
    tick(70);
    chk("gto_idle", 32'(bg0), 32'hF);

    // Bus timer: DS0 low with no acknowledge -> BERR at clock 1027
    pulse_reset();
    ds_n = 2'b10;
    tick(1026);
    chk("bt_before", 32'(berro0), 32'h1);
    chk("bt_flag_before", 32'(tof0), 32'h0);
    tick(1);
    chk("bt_berr", 32'(berro0), 32'h0);
    chk("bt_flag", 32'(tof0), 32'h1);
    tick(1);
    chk("bt_flag_once", 32'(tof0), 32'h0);
    chk("bt_berr_hold", 32'(berro0), 32'h0);
    tick(20);
    chk("bt_no_repulse", 32'(tof0), 32'h0);
    ds_n = 2'b11;
    tick(2);
    chk("bt_release_wait", 32'(berro0), 32'h0);
    tick(1);
    chk("bt_release", 32'(berro0), 32'h1);
    tick(5);

    // DTACK near expiry: early and exactly-at-expiry win, one cycle late loses
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back((offs[k] >= 1025) ? 32'd1 : 32'd0);
      ds_n = 2'b10;
      dtack_n = 1'b1;
      berr_seen = 1'b0;
      pulses = 0;
      for (int c = 1; c <= 1100; c++) begin
        tick(1);
        if (berro0 == 1'b0) berr_seen = 1'b1;
        if (tof0 == 1'b1) pulses++;
        if (c == offs[k]) dtack_n = 1'b0;
      end
      e = exp_q.pop_front();
      chk("dtack_berr", 32'(berr_seen), e);
      chk("dtack_pulses", 32'(pulses), e);
      ds_n = 2'b11;
      dtack_n = 1'b1;
      tick(5);
    end

    // Asynchronous reset in BUSY with BCLR and BERR asserted
    pulse_reset();
    br_n = 4'b1101;
    wait_sig(0, 4'b1101, "ar_grant1");
    bbsy_n = 1'b0;
    br_n = 4'b1011;
    ds_n = 2'b10;
    wait_sig(2, 4'd0, "ar_busy");
    tick(5);
    chk("ar_pre_bclr", 32'(bclr0), 32'h0);
    tick(1030);
    chk("ar_pre_berr", 32'(berro0), 32'h0);
    chk("ar_pre_lvl", 32'(lvl0), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_bg", 32'(bg0), 32'hF);
    chk("ar_bclr", 32'(bclr0), 32'h1);
    chk("ar_berr", 32'(berro0), 32'h1);
    chk("ar_tof", 32'(tof0), 32'h0);
    chk("ar_lvl", 32'(lvl0), 32'h0);
    chk("ar_led", 32'(led0), 32'h1);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    chk("bbsy_at_reset_idle", 32'(bg0), 32'hF);

    // syscon_en low in BUSY with BCLR and BERR asserted: synchronous clear
    bbsy_n = 1'b1;
    wait_sig(0, 4'b1011, "se_grant2");
    bbsy_n = 1'b0;
    br_n = 4'b0011;
    wait_sig(2, 4'd0, "se_busy");
    tick(1030);
    chk("se_pre_bclr", 32'(bclr0), 32'h0);
    chk("se_pre_berr", 32'(berro0), 32'h0);
    syscon_en = 1'b0;
    #1;
    chk("se_not_async", 32'(bclr0), 32'h0);
    tick(1);
    chk("se_bg", 32'(bg0), 32'hF);
    chk("se_bclr", 32'(bclr0), 32'h1);
    chk("se_berr", 32'(berro0), 32'h1);
    chk("se_tof", 32'(tof0), 32'h0);
    chk("se_lvl", 32'(lvl0), 32'h0);
    chk("se_led", 32'(led0), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
